// File: rtl/core_pipe.sv
// rtl/core_pipe.sv - 3-stage RV32I core (IF / EX / WB) with unified 64 KiB byte memory
// Optional CSR, ECALL and MRET support is enabled by defining CORE_CSR_EN.
module core_pipe_mem (
    input  logic        clk,
    input  logic [15:0] fetch_addr,
    output logic [31:0] fetch_data,
    input  logic [15:0] ld_addr,
    output logic [31:0] ld_data,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  wr_bytes
);
    logic [7:0] m [0:65535];

    // Every access is assembled byte by byte so misaligned and wrapping accesses need no special case
    always_comb begin
        fetch_data = {m[fetch_addr + 16'd3], m[fetch_addr + 16'd2],
                      m[fetch_addr + 16'd1], m[fetch_addr]};
        ld_data    = {m[ld_addr + 16'd3], m[ld_addr + 16'd2],
                      m[ld_addr + 16'd1], m[ld_addr]};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < wr_bytes) begin
                    m[wr_addr + 16'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end
endmodule

module core_pipe (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [31:0] if_pc, if_pc_d;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] ex_ir_q, ex_ir_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_wen_q, wb_wen_d;
    logic        wb_load_q, wb_load_d;
    logic        wb_store_q, wb_store_d;
    logic [2:0]  wb_f3_q, wb_f3_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_val_q, wb_val_d;
    logic [31:0] wb_sdata_q, wb_sdata_d;

    logic [31:0] fetch_word, ld_word, ld_ext, wb_wdata;
    logic        mem_we;
    logic [2:0]  mem_bytes;

    core_pipe_mem memory (
        .clk        (clk),
        .fetch_addr (if_pc[15:0]),
        .fetch_data (fetch_word),
        .ld_addr    (wb_val_q[15:0]),
        .ld_data    (ld_word),
        .wr_en      (mem_we),
        .wr_addr    (wb_val_q[15:0]),
        .wr_data    (wb_sdata_q),
        .wr_bytes   (mem_bytes)
    );

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1a, rs2a;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ex_ir_q[6:0];
    assign rd     = ex_ir_q[11:7];
    assign f3     = ex_ir_q[14:12];
    assign rs1a   = ex_ir_q[19:15];
    assign rs2a   = ex_ir_q[24:20];
    assign imm_i  = {{20{ex_ir_q[31]}}, ex_ir_q[31:20]};
    assign imm_s  = {{20{ex_ir_q[31]}}, ex_ir_q[31:25], ex_ir_q[11:7]};
    assign imm_b  = {{19{ex_ir_q[31]}}, ex_ir_q[31], ex_ir_q[7], ex_ir_q[30:25], ex_ir_q[11:8], 1'b0};
    assign imm_u  = {ex_ir_q[31:12], 12'b0};
    assign imm_j  = {{11{ex_ir_q[31]}}, ex_ir_q[31], ex_ir_q[19:12], ex_ir_q[20], ex_ir_q[30:21], 1'b0};

    logic        use1, use2, stall, fire, redirect;
    logic [31:0] r1, r2;

    // Loads are never forwarded; the load-use case stalls instead, so WB only forwards ALU-class results
    always_comb begin
        use1 = (opcode == OP_JALR) || (opcode == OP_BRANCH) || (opcode == OP_LOAD) ||
               (opcode == OP_STORE) || (opcode == OP_IMM) || (opcode == OP_REG);
`ifdef CORE_CSR_EN
        if (opcode == OP_SYSTEM && f3[2] == 1'b0 && f3[1:0] != 2'b00) use1 = 1'b1;
`endif
        use2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_REG);
        if (rs1a == 5'd0)
            r1 = '0;
        else if (wb_valid_q && wb_wen_q && !wb_load_q && wb_rd_q == rs1a)
            r1 = wb_val_q;
        else
            r1 = rs[rs1a];
        if (rs2a == 5'd0)
            r2 = '0;
        else if (wb_valid_q && wb_wen_q && !wb_load_q && wb_rd_q == rs2a)
            r2 = wb_val_q;
        else
            r2 = rs[rs2a];
        stall = ex_valid_q && wb_valid_q && wb_load_q && wb_rd_q != 5'd0 &&
                ((use1 && rs1a == wb_rd_q) || (use2 && rs2a == wb_rd_q));
    end

    logic [31:0] alu_b, alu_res;
    logic [4:0]  shamt;
    logic        eq, lt, ltu;

    always_comb begin
        alu_b = (opcode == OP_REG) ? r2 : imm_i;
        shamt = alu_b[4:0];
        eq    = (r1 == r2);
        lt    = ($signed(r1) < $signed(r2));
        ltu   = (r1 < r2);
        case (f3)
            3'b000:  alu_res = (opcode == OP_REG && ex_ir_q[30]) ? r1 - alu_b : r1 + alu_b;
            3'b001:  alu_res = r1 << shamt;
            3'b010:  alu_res = {31'b0, $signed(r1) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, r1 < alu_b};
            3'b100:  alu_res = r1 ^ alu_b;
            3'b101:  alu_res = ex_ir_q[30] ? 32'($signed(r1) >>> shamt) : r1 >> shamt;
            3'b110:  alu_res = r1 | alu_b;
            default: alu_res = r1 & alu_b;
        endcase
    end

    logic        ex_wen, ex_load, ex_store, ex_take;
    logic [31:0] ex_result, ex_target;
`ifdef CORE_CSR_EN
    logic        csr_we, ex_ecall;
    logic [11:0] csr_addr;
    logic [31:0] csr_old, csr_src, csr_wdata;
`endif

    always_comb begin
        ex_wen    = 1'b0;
        ex_load   = 1'b0;
        ex_store  = 1'b0;
        ex_take   = 1'b0;
        ex_result = '0;
        ex_target = '0;
`ifdef CORE_CSR_EN
        csr_we    = 1'b0;
        ex_ecall  = 1'b0;
        csr_addr  = ex_ir_q[31:20];
        csr_old   = csr[csr_addr];
        csr_src   = f3[2] ? {27'b0, rs1a} : r1;
        csr_wdata = '0;
`endif
        case (opcode)
            OP_LUI:   begin ex_wen = 1'b1; ex_result = imm_u; end
            OP_AUIPC: begin ex_wen = 1'b1; ex_result = ex_pc_q + imm_u; end
            OP_JAL: begin
                ex_wen = 1'b1; ex_result = ex_pc_q + 32'd4;
                ex_take = 1'b1; ex_target = ex_pc_q + imm_j;
            end
            OP_JALR: if (f3 == 3'b000) begin
                ex_wen = 1'b1; ex_result = ex_pc_q + 32'd4;
                ex_take = 1'b1; ex_target = (r1 + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                ex_target = ex_pc_q + imm_b;
                case (f3)
                    3'b000:  ex_take = eq;
                    3'b001:  ex_take = !eq;
                    3'b100:  ex_take = lt;
                    3'b101:  ex_take = !lt;
                    3'b110:  ex_take = ltu;
                    3'b111:  ex_take = !ltu;
                    default: ex_take = 1'b0;
                endcase
            end
            OP_LOAD: if (f3 != 3'b011 && f3[2:1] != 2'b11) begin
                ex_wen = 1'b1; ex_load = 1'b1; ex_result = r1 + imm_i;
            end
            OP_STORE: if (f3[2] == 1'b0 && f3[1:0] != 2'b11) begin
                ex_store = 1'b1; ex_result = r1 + imm_s;
            end
            OP_IMM, OP_REG: begin ex_wen = 1'b1; ex_result = alu_res; end
`ifdef CORE_CSR_EN
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    if (ex_ir_q[31:20] == 12'h000) begin
                        ex_ecall = 1'b1; ex_take = 1'b1; ex_target = csr[12'h305];
                    end else if (ex_ir_q[31:20] == 12'h302) begin
                        ex_take = 1'b1; ex_target = csr[12'h341];
                    end
                end else if (f3[1:0] != 2'b00) begin
                    csr_we = 1'b1; ex_wen = 1'b1; ex_result = csr_old;
                    case (f3[1:0])
                        2'b01:   csr_wdata = csr_src;
                        2'b10:   csr_wdata = csr_old | csr_src;
                        default: csr_wdata = csr_old & ~csr_src;
                    endcase
                end
            end
`endif
            default: ;
        endcase
    end

    assign fire     = ex_valid_q && !stall;
    assign redirect = fire && ex_take;

    always_comb begin
        if_pc_d    = if_pc;
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_ir_d    = ex_ir_q;
        if (redirect) begin
            if_pc_d    = ex_target;
            ex_valid_d = 1'b0;
        end else if (!stall) begin
            if_pc_d    = if_pc + 32'd4;
            ex_valid_d = 1'b1;
            ex_pc_d    = if_pc;
            ex_ir_d    = fetch_word;
        end
        wb_valid_d = fire;
        wb_wen_d   = ex_wen;
        wb_load_d  = ex_load;
        wb_store_d = ex_store;
        wb_f3_d    = f3;
        wb_rd_d    = rd;
        wb_val_d   = ex_result;
        wb_sdata_d = r2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_pc      <= '0;
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_ir_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_load_q  <= 1'b0;
            wb_store_q <= 1'b0;
            wb_f3_q    <= '0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
            wb_sdata_q <= '0;
        end else begin
            if_pc      <= if_pc_d;
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_ir_q    <= ex_ir_d;
            wb_valid_q <= wb_valid_d;
            wb_wen_q   <= wb_wen_d;
            wb_load_q  <= wb_load_d;
            wb_store_q <= wb_store_d;
            wb_f3_q    <= wb_f3_d;
            wb_rd_q    <= wb_rd_d;
            wb_val_q   <= wb_val_d;
            wb_sdata_q <= wb_sdata_d;
        end
    end

    always_comb begin
        case (wb_f3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_ext = {24'b0, ld_word[7:0]};
            3'b101:  ld_ext = {16'b0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
        wb_wdata = wb_load_q ? ld_ext : wb_val_q;
        mem_we   = wb_valid_q && wb_store_q;
        case (wb_f3_q[1:0])
            2'b00:   mem_bytes = 3'd1;
            2'b01:   mem_bytes = 3'd2;
            default: mem_bytes = 3'd4;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rs[i] <= '0;
        end else if (wb_valid_q && wb_wen_q && wb_rd_q != 5'd0) begin
            rs[wb_rd_q] <= wb_wdata;
        end
    end

`ifdef CORE_CSR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4096; i++) csr[i] <= '0;
        end else if (fire) begin
            if (csr_we) csr[csr_addr] <= csr_wdata;
            if (ex_ecall) begin
                csr[12'h341] <= ex_pc_q;
                csr[12'h342] <= 32'd11;
            end
        end
    end
`else
    // Without CSR support the file is architecturally present but frozen at its reset contents
    always_comb begin
        for (int i = 0; i < 4096; i++) csr[i] = '0;
    end
`endif
endmodule

// File: tb/tb_core_pipe.sv
// tb/tb_core_pipe.sv - directed and random program checks of core_pipe against an ISA-level model
module tb_core_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;

    core_pipe dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  mm [0:65535];
    logic [31:0] mr [0:31];
    logic [31:0] mpc;
    logic [31:0] prog [$];

    localparam logic [31:0] HALT = 32'h0000006f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] s1, input logic [31:0] imm);
        return {imm[11:0], s1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, s2, s1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] imm);
        return {imm[11:5], s2, s1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] imm);
        return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        return {mm[a + 16'd3], mm[a + 16'd2], mm[a + 16'd1], mm[a]};
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // One instruction at architectural level: no pipeline, no forwarding, no timing
    task automatic model_step();
        logic [31:0] w, r1, r2, res, nxt, ii, ld, addr;
        logic [15:0] a;
        logic [2:0]  f3;
        logic        wr, tk;
        w = rd_word(mpc[15:0]);
        f3 = w[14:12];
        r1 = mr[w[19:15]];
        r2 = mr[w[24:20]];
        ii = {{20{w[31]}}, w[31:20]};
        nxt = mpc + 4;
        wr = 1'b0;
        res = '0;
        case (w[6:0])
            7'h37: begin wr = 1'b1; res = {w[31:12], 12'b0}; end
            7'h17: begin wr = 1'b1; res = mpc + {w[31:12], 12'b0}; end
            7'h6f: begin
                wr = 1'b1; res = mpc + 4;
                nxt = mpc + {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: begin wr = 1'b1; res = mpc + 4; nxt = (r1 + ii) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (r1 == r2);
                    3'd1: tk = (r1 != r2);
                    3'd4: tk = ($signed(r1) < $signed(r2));
                    3'd5: tk = ($signed(r1) >= $signed(r2));
                    3'd6: tk = (r1 < r2);
                    3'd7: tk = (r1 >= r2);
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = mpc + {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h03: begin
                addr = r1 + ii;
                ld = rd_word(addr[15:0]);
                wr = 1'b1;
                case (f3)
                    3'd0: res = {{24{ld[7]}}, ld[7:0]};
                    3'd1: res = {{16{ld[15]}}, ld[15:0]};
                    3'd2: res = ld;
                    3'd4: res = {24'b0, ld[7:0]};
                    default: res = {16'b0, ld[15:0]};
                endcase
            end
            7'h23: begin
                addr = r1 + {{20{w[31]}}, w[31:25], w[11:7]};
                a = addr[15:0];
                for (int k = 0; k < (1 << f3); k++) mm[a + 16'(k)] = r2[8*k +: 8];
            end
            7'h13: begin wr = 1'b1; res = m_alu(f3, (f3 == 3'd5) && w[30], r1, ii); end
            7'h33: begin wr = 1'b1; res = m_alu(f3, w[30], r1, r2); end
            default: ;
        endcase
        if (wr && w[11:7] != 5'd0) mr[w[11:7]] = res;
        mpc = nxt;
    endtask

    task automatic load_prog();
        for (int k = 0; k < prog.size(); k++) begin
            for (int b = 0; b < 4; b++) begin
                dut.memory.m[4*k + b] = prog[k][8*b +: 8];
                mm[4*k + b] = prog[k][8*b +: 8];
            end
        end
    endtask

    task automatic model_run(output int steps);
        for (int r = 0; r < 32; r++) mr[r] = '0;
        mpc = '0;
        steps = 0;
        while (rd_word(mpc[15:0]) != HALT && steps < 2000) begin
            model_step();
            steps++;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cmp_regs(input string tag);
        for (int r = 1; r < 32; r++) check($sformatf("%s_x%0d", tag, r), dut.rs[r], mr[r]);
    endtask

    task automatic cmp_mem(input string tag);
        int mism = 0;
        for (int a = 16'h200; a < 16'h304; a++) if (dut.memory.m[a] !== mm[a]) mism++;
        check({tag, "_mem"}, 32'(mism), 32'd0);
    endtask

    task automatic gen_random(input int n);
        logic [4:0]  rd, s1, s2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [2:0]  ltab [5];
        logic [2:0]  btab [6];
        ltab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        btab = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        prog.delete();
        for (int i = 0; i < n; i++) begin
            rd  = 5'($urandom_range(1, 7));
            s1  = 5'($urandom_range(0, 7));
            s2  = 5'($urandom_range(0, 7));
            f3  = 3'($urandom_range(0, 7));
            imm = $urandom;
            case ($urandom_range(0, 9))
                0, 1: begin
                    if (f3 == 3'd1) imm = {27'b0, imm[4:0]};
                    if (f3 == 3'd5) imm = {20'b0, 1'b0, imm[30], 5'b0, imm[4:0]};
                    prog.push_back(enc_i(7'h13, f3, rd, s1, imm));
                end
                2, 3: prog.push_back(enc_r(((f3 == 3'd0 || f3 == 3'd5) && imm[31]) ? 7'h20 : 7'h00,
                                           s2, s1, f3, rd));
                4: prog.push_back({imm[31:12], rd, 7'h37});
                5: prog.push_back(enc_s(3'($urandom_range(0, 2)), 5'd0, s2, 32'h200 + $urandom_range(0, 255)));
                6: prog.push_back(enc_i(7'h03, ltab[$urandom_range(0, 4)], rd, 5'd0,
                                        32'h200 + $urandom_range(0, 255)));
                7: if (i < n - 3)
                       prog.push_back(enc_b(btab[$urandom_range(0, 5)], s1, s2, imm[0] ? 32'd8 : 32'd12));
                   else
                       prog.push_back(enc_i(7'h13, 3'd0, rd, s1, imm));
                8: if (i < n - 3) prog.push_back(enc_j(rd, 32'd8));
                   else prog.push_back({imm[31:12], rd, 7'h17});
                default: prog.push_back({imm[31:12], rd, 7'h17});
            endcase
        end
        prog.push_back(HALT);
    endtask

    initial begin
        int steps;
        logic [31:0] orr;
        logic [31:0] e3, e4, e341, e305;

        for (int i = 0; i < 65536; i++) begin
            dut.memory.m[i] = 8'h00;
            mm[i] = 8'h00;
        end
        #12;
        check("reset_if_pc", dut.if_pc, 32'd0);
        orr = '0;
        for (int r = 0; r < 32; r++) orr |= dut.rs[r];
        check("reset_regs", orr, 32'd0);
        check("reset_mhartid", dut.csr[12'hF14], 32'd0);

        // Forwarding of a WB result into the very next instruction
        prog = '{enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'd5), enc_i(7'h13, 3'd0, 5'd2, 5'd1, 32'd3), HALT};
        load_prog();
        model_run(steps);
        release_reset();
        repeat (3 * steps + 20) @(posedge clk);
        #1;
        check("fwd_x2", dut.rs[2], 32'd8);
        cmp_regs("fwd");

        // Taken BLTU skips one instruction; if_pc lands on the target one edge after EX resolves it
        rst = 1'b0;
        #1;
        prog = '{enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'hFFFF_FFFF), enc_i(7'h13, 3'd0, 5'd2, 5'd0, 32'd1),
                 enc_b(3'd6, 5'd2, 5'd1, 32'd8), enc_i(7'h13, 3'd0, 5'd3, 5'd0, 32'd7),
                 enc_i(7'h13, 3'd0, 5'd4, 5'd0, 32'd9), HALT};
        load_prog();
        model_run(steps);
        release_reset();
        repeat (4) @(posedge clk);
        #1;
        check("bltu_if_pc_target", dut.if_pc, 32'd16);
        repeat (20) @(posedge clk);
        #1;
        check("bltu_skipped_x3", dut.rs[3], 32'd0);
        check("bltu_target_x4", dut.rs[4], 32'd9);
        cmp_regs("bltu");

        // Unsigned vs signed compare on 0xFFFFFFFF and 1
        rst = 1'b0;
        #1;
        prog = '{enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'hFFFF_FFFF), enc_i(7'h13, 3'd0, 5'd2, 5'd0, 32'd1),
                 enc_b(3'd6, 5'd1, 5'd2, 32'd8), enc_i(7'h13, 3'd0, 5'd3, 5'd0, 32'd1),
                 enc_b(3'd4, 5'd1, 5'd2, 32'd8), enc_i(7'h13, 3'd0, 5'd4, 5'd0, 32'd1), HALT};
        load_prog();
        model_run(steps);
        release_reset();
        repeat (3 * steps + 20) @(posedge clk);
        #1;
        check("bltu_not_taken_x3", dut.rs[3], 32'd1);
        check("blt_taken_x4", dut.rs[4], 32'd0);

        // Byte loads, misaligned and wrapping accesses, load-use stall and JALR bit-0 clearing
        rst = 1'b0;
        #1;
        prog = '{{20'h80402, 5'd1, 7'h37}, enc_i(7'h13, 3'd0, 5'd1, 5'd1, 32'h010),
                 enc_s(3'd2, 5'd0, 5'd1, 32'h100), enc_i(7'h03, 3'd0, 5'd2, 5'd0, 32'h103),
                 enc_i(7'h03, 3'd4, 5'd3, 5'd0, 32'h103), enc_i(7'h03, 3'd2, 5'd4, 5'd0, 32'h101),
                 enc_s(3'd2, 5'd0, 5'd1, 32'hFFFF_FFFE), enc_i(7'h03, 3'd2, 5'd5, 5'd0, 32'hFFFF_FFFE),
                 enc_i(7'h03, 3'd2, 5'd6, 5'd0, 32'h100), enc_i(7'h13, 3'd0, 5'd7, 5'd6, 32'd1),
                 {20'h0, 5'd8, 7'h17}, enc_i(7'h67, 3'd0, 5'd9, 5'd8, 32'd13),
                 enc_i(7'h13, 3'd0, 5'd10, 5'd0, 32'd1), HALT};
        load_prog();
        model_run(steps);
        release_reset();
        repeat (3 * steps + 20) @(posedge clk);
        #1;
        check("lb_sext", dut.rs[2], 32'hFFFF_FF80);
        check("lbu_zext", dut.rs[3], 32'h0000_0080);
        check("lw_misaligned", dut.rs[4], 32'h0080_4020);
        check("lw_wrap", dut.rs[5], 32'h8040_2010);
        check("load_use", dut.rs[7], 32'h8040_2011);
        check("jalr_link", dut.rs[9], 32'd48);
        check("jalr_skip", dut.rs[10], 32'd0);
        check("wrap_byte0", {24'b0, dut.memory.m[0]}, 32'h40);
        cmp_regs("mem");

        // SYSTEM instructions: trap flow when CSRs exist, NOPs otherwise
        rst = 1'b0;
        #1;
        prog = '{enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'h40), enc_i(7'h73, 3'd1, 5'd2, 5'd1, 32'h305),
                 32'h0000_0073, enc_i(7'h13, 3'd0, 5'd4, 5'd0, 32'd7), HALT};
        while (prog.size() < 16) prog.push_back(HALT);
        prog.push_back(enc_i(7'h73, 3'd2, 5'd3, 5'd0, 32'h342));
        prog.push_back(HALT);
        load_prog();
`ifdef CORE_CSR_EN
        e3 = 32'd11; e4 = 32'd0; e341 = 32'd8; e305 = 32'h40;
`else
        e3 = 32'd0; e4 = 32'd7; e341 = 32'd0; e305 = 32'd0;
`endif
        release_reset();
        repeat (40) @(posedge clk);
        #1;
        check("sys_x3", dut.rs[3], e3);
        check("sys_x4", dut.rs[4], e4);
        check("sys_mepc", dut.csr[12'h341], e341);
        check("sys_mtvec", dut.csr[12'h305], e305);

        // Random straight-line programs with forward branches and jumps
        for (int p = 0; p < 6; p++) begin
            rst = 1'b0;
            #1;
            gen_random(40);
            load_prog();
            model_run(steps);
            release_reset();
            repeat (3 * steps + 20) @(posedge clk);
            #1;
            cmp_regs($sformatf("rand%0d", p));
            cmp_mem($sformatf("rand%0d", p));
        end

        // Asynchronous reset in the middle of a program
        rst = 1'b0;
        #1;
        gen_random(40);
        load_prog();
        release_reset();
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_if_pc", dut.if_pc, 32'd0);
        orr = '0;
        for (int r = 0; r < 32; r++) orr |= dut.rs[r];
        check("midreset_regs", orr, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/core_pipe.md
CORE_PIPE -- requirements
Module: Core

Interface
REQ-001 The block SHALL have no parameters; memory size is fixed at 65536 bytes.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have no other ports; state is observable hierarchically.
- memory.m[0:65535]: 8-bit, byte-addressed unified instruction/data memory, little-endian, loadable by $readmemh.
- rs[0:31]: 32-bit register file.
- csr[0:4095]: 32-bit CSR file.
- if_pc: 32-bit fetch PC.

Function
REQ-005 The block SHALL implement RV32I:
- LUI, AUIPC, JAL, JALR
- BEQ/BNE/BLT/BGE/BLTU/BGEU
- LB/LH/LW/LBU/LHU, SB/SH/SW
- all OP-IMM and OP instructions
- FENCE as NOP.
REQ-006 The block SHALL use a 3-stage pipeline:
- IF: fetch word at if_pc.
- EX: decode, register read, ALU, branch resolve, CSR.
- WB: memory access and register writeback.
REQ-007 IF SHALL advance if_pc by 4 each cycle unless a redirect occurs.
REQ-008 A taken branch, jump, ECALL or MRET resolved in EX SHALL load if_pc with the target on the next edge and squash the instruction in IF as a bubble (1-cycle penalty).
REQ-009 BLTU/BGEU SHALL compare unsigned 32-bit; BLT/BGE SHALL compare signed; branch target = pc + sign-extended B-immediate.
REQ-010 JALR target SHALL be (rs1 + imm) with bit 0 cleared.
REQ-011 Writes to rs[0] SHALL be discarded; reads of x0 SHALL return 0.
REQ-012 A result in WB SHALL be forwarded to an EX operand reading the same nonzero register.
REQ-013 A load followed immediately by a dependent instruction SHALL stall IF/EX one cycle.
REQ-014 Loads SHALL sign-extend (LB/LH) or zero-extend (LBU/LHU); addresses SHALL use bits [15:0] and wrap modulo 65536.
REQ-015 Misaligned accesses SHALL be performed byte-wise without trapping.
REQ-016 Shifts SHALL use only the low 5 bits of the shift amount; SRA/SRAI SHALL be arithmetic.
REQ-017 Undefined opcodes SHALL execute as NOP.

Reset
REQ-018 While rst=0, the block SHALL asynchronously set:
- if_pc=0
- all pipeline valid bits=0 (bubbles)
- rs[0..31]=0
- csr[0..4095]=0, except csr[0xF14] (mhartid)=0.
REQ-019 memory.m SHALL NOT be altered by reset.
REQ-020 The first fetch SHALL be at address 0 on the first rising edge after rst returns high.
REQ-021 Assertion of rst mid-operation SHALL abort all in-flight instructions without any register or memory write.

Configuration
REQ-022 With macro CORE_CSR_EN defined:
- CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI SHALL read-modify-write csr[imm[11:0]] and write the old value to rd.
- ECALL SHALL set mepc(0x341)=pc and mcause(0x342)=11, then redirect to mtvec(0x305).
- MRET SHALL redirect to mepc.
REQ-023 Without CORE_CSR_EN:
- All SYSTEM-opcode instructions SHALL execute as NOP.
- The csr array SHALL still exist and hold its reset values.

Verification
REQ-024 Reset, then a program of ADDI x1,x0,5; ADDI x2,x1,3 -> rs[2]=8 (forwarding).
REQ-025 ADDI x1,x0,-1; ADDI x2,x0,1; BLTU x2,x1,+8 -> branch taken, skipped instruction has no effect, if_pc follows target.
REQ-026 BLTU x1,x2 with x1=0xFFFFFFFF, x2=1 -> not taken; BLT with the same values -> taken.
REQ-027 SW 0x80402010 to 0x100, then LB/LBU at 0x103 -> 0xFFFFFF80 / 0x00000080.
REQ-028 Load the rv32ui-p-bltu test image, release reset, run at most 6000 cycles -> if_pc reaches 0x44 with rs[3]=1 (CORE_CSR_EN defined).
REQ-029 Assert rst mid-program -> if_pc=0 and rs all zero immediately, without waiting for a clock edge.
